// File: rtl/cache_line_arbiter.sv
// rtl/cache_line_arbiter.sv - round-robin arbiter sharing one memory line port between I-cache and D-cache
module cache_line_arbiter #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_resp_q, i_resp_d;
  logic                d_resp_q, d_resp_d;

  logic                d_req;
  logic                grant_valid;
  logic                grant_side;

  // On a tie the side that did not win last time goes next, so neither cache can starve.
  always_comb begin
    d_req       = d_read | d_write;
    grant_valid = i_read | d_req;
    if (i_read && d_req) begin
      grant_side = ~last_grant_q;
    end else begin
      grant_side = d_req ? SIDE_D : SIDE_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= SIDE_I;
      last_grant_q <= SIDE_I;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_resp_q     <= i_resp_d;
      d_resp_q     <= d_resp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = BUSY;
      BUSY:    if (mem_resp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_resp_d     = 1'b0;
    d_resp_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d      = grant_side;
          last_grant_d = grant_side;
          if (grant_side == SIDE_D) begin
            // A simultaneous read and write from the D-cache is resolved as a write.
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_write_d = d_write;
            mem_read_d  = ~d_write;
          end else begin
            mem_addr_d  = i_addr;
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
          end
        end
      end
      BUSY: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (!mem_write_q) begin
            if (owner_q == SIDE_D) d_rdata_d = mem_rdata;
            else                   i_rdata_d = mem_rdata;
          end
          i_resp_d = (owner_q == SIDE_I);
          d_resp_d = (owner_q == SIDE_D);
        end
      end
      default: begin
      end
    endcase
  end

  assign i_rdata   = i_rdata_q;
  assign i_resp    = i_resp_q;
  assign d_rdata   = d_rdata_q;
  assign d_resp    = d_resp_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cache_line_arbiter.sv
// tb/tb_cache_line_arbiter.sv - directed scoreboard bench for cache_line_arbiter
module tb_cache_line_arbiter;

  logic         clk;
  logic         rst;
  logic         i_read;
  logic [15:0]  i_addr;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_addr;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_resp;

  cache_line_arbiter #(.LINE_W(128), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  typedef struct {
    bit           is_d;
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  txn_t         sb[$];
  int           total = 0;
  int           bad = 0;
  logic [127:0] exp_i = '0;
  logic [127:0] exp_d = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, "_mem_read"}, mem_read, 1'b0);
    chk1({tag, "_mem_write"}, mem_write, 1'b0);
    chk1({tag, "_i_resp"}, i_resp, 1'b0);
    chk1({tag, "_d_resp"}, d_resp, 1'b0);
    chk({tag, "_i_rdata"}, i_rdata, exp_i);
    chk({tag, "_d_rdata"}, d_rdata, exp_d);
  endtask

  // Waits for the next memory strobe, checks it against the scoreboard head, then plays memory.
  task automatic mem_txn(input int glat, input int lat, input logic [127:0] rdata, input bit drop);
    txn_t e;
    int   n;
    n = 0;
    while (!(mem_read || mem_write) && n < 20) begin
      tick();
      n++;
    end
    chk1("grant_seen", mem_read | mem_write, 1'b1);
    if (!(mem_read || mem_write)) return;
    chk_int("grant_latency", n, glat);
    chk1("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk1("mem_write", mem_write, e.wr);
    chk1("mem_read", mem_read, !e.wr);
    chk("mem_addr", 128'(mem_addr), 128'(e.addr));
    if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
    repeat (lat) begin
      tick();
      chk1("busy_read", mem_read, !e.wr);
      chk1("busy_write", mem_write, e.wr);
      chk("busy_addr", 128'(mem_addr), 128'(e.addr));
      if (e.wr) chk("busy_wdata", mem_wdata, e.wdata);
      chk1("busy_i_resp", i_resp, 1'b0);
      chk1("busy_d_resp", d_resp, 1'b0);
    end
    mem_resp  = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_resp  = 1'b0;
    mem_rdata = ~rdata;
    if (!e.wr) begin
      if (e.is_d) exp_d = rdata;
      else        exp_i = rdata;
    end
    chk1("done_mem_read", mem_read, 1'b0);
    chk1("done_mem_write", mem_write, 1'b0);
    chk1("done_i_resp", i_resp, !e.is_d);
    chk1("done_d_resp", d_resp, e.is_d);
    chk("done_i_rdata", i_rdata, exp_i);
    chk("done_d_rdata", d_rdata, exp_d);
    if (drop) begin
      if (e.is_d) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end else begin
        i_read = 1'b0;
      end
    end
    tick();
    chk_quiet("after_done");
  endtask

  function automatic txn_t mk(input bit is_d, input bit wr, input logic [15:0] addr,
                              input logic [127:0] wdata);
    txn_t t;
    t.is_d  = is_d;
    t.wr    = wr;
    t.addr  = addr;
    t.wdata = wdata;
    return t;
  endfunction

  initial begin
    rst       = 1'b1;
    i_read    = 1'b1;
    i_addr    = 16'h1110;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_resp  = 1'b0;

    tick();
    chk_quiet("reset_c1");
    chk("reset_c1_mem_addr", 128'(mem_addr), 128'(0));
    chk("reset_c1_mem_wdata", mem_wdata, 128'(0));
    tick();
    chk_quiet("reset_c2");
    rst = 1'b0;
    sb.push_back(mk(1'b0, 1'b0, 16'h1110, '0));
    mem_txn(1, 1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1);

    i_addr = 16'h1230;
    i_read = 1'b1;
    sb.push_back(mk(1'b0, 1'b0, 16'h1230, '0));
    mem_txn(1, 3, 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE, 1'b1);

    d_addr  = 16'h4A50;
    d_wdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    d_write = 1'b1;
    sb.push_back(mk(1'b1, 1'b1, 16'h4A50, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210));
    mem_txn(1, 2, {4{$urandom}}, 1'b1);

    mem_resp  = 1'b1;
    mem_rdata = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
    tick();
    mem_resp = 1'b0;
    chk_quiet("stray_idle_c1");
    tick();
    chk_quiet("stray_idle_c2");

    rst = 1'b1;
    tick();
    rst   = 1'b0;
    exp_i = '0;
    exp_d = '0;
    chk_quiet("reset_again");
    i_addr = 16'h2000;
    i_read = 1'b1;
    d_addr = 16'h3000;
    d_read = 1'b1;
    sb.push_back(mk(1'b1, 1'b0, 16'h3000, '0));
    sb.push_back(mk(1'b0, 1'b0, 16'h2000, '0));
    sb.push_back(mk(1'b1, 1'b0, 16'h3000, '0));
    sb.push_back(mk(1'b0, 1'b0, 16'h2000, '0));
    mem_txn(1, 1, 128'hD1D1_0000_0000_0000_0000_0000_0000_0001, 1'b0);
    mem_txn(1, 2, 128'hA1A1_0000_0000_0000_0000_0000_0000_0002, 1'b0);
    mem_txn(1, 0, 128'hD2D2_0000_0000_0000_0000_0000_0000_0003, 1'b0);
    mem_txn(1, 1, 128'hA2A2_0000_0000_0000_0000_0000_0000_0004, 1'b1);

    tick();
    chk1("regrant_d_read", mem_read, 1'b1);
    chk("regrant_d_addr", 128'(mem_addr), 128'(16'h3000));
    tick();
    rst    = 1'b1;
    d_read = 1'b0;
    tick();
    rst   = 1'b0;
    exp_i = '0;
    exp_d = '0;
    chk_quiet("mid_busy_reset");
    chk("mid_busy_reset_mem_addr", 128'(mem_addr), 128'(0));
    mem_resp  = 1'b1;
    mem_rdata = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
    tick();
    mem_resp = 1'b0;
    chk_quiet("late_resp_c1");
    tick();
    chk_quiet("late_resp_c2");

    d_addr  = 16'h5A5A;
    d_wdata = 128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0;
    d_read  = 1'b1;
    d_write = 1'b1;
    sb.push_back(mk(1'b1, 1'b1, 16'h5A5A, 128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0));
    mem_txn(1, 1, {4{$urandom}}, 1'b1);

    i_addr = 16'h7770;
    i_read = 1'b1;
    sb.push_back(mk(1'b0, 1'b0, 16'h7770, '0));
    mem_txn(1, 0, 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878, 1'b1);

    chk_int("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
